uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive stage of the UART, directly downstream of the transmit path: it consumes the `Tx` line (looped or external) as `Rx` and reassembles one `DATA_WIDTH`-bit word from consecutive character frames using the same frame_length / parity_signal / stop_bits configuration. It runs on the system clock with a 16x-baud `rx_tick` enable, samples each bit at mid-point, checks parity and stop bits, and hands the word and status to the register block.

## Interface
- `DATA_WIDTH`, 32: assembled word width, taken from the shared define.
- `OVERSAMPLE`, 16: `rx_tick` pulses per bit period. Must be a power of two.
- `PCLK`  in  1  system clock, rising edge.
- `PRESETn`  in  1  reset, asynchronous, active-low.
- `rx_tick`  in  1  one-PCLK enable pulse at OVERSAMPLE x baud.
- `RX_enable`  in  1  receive enable. Low forces IDLE and clears the partial word.
- `Rx`  in  1  asynchronous serial input. Idle is 1.
- `frame_length`  in  4  data bits per frame. Legal values are 5 to 8.
- `parity_signal`  in  2  bit1 enables parity. With bit1 set, bit0=0 selects odd parity and bit0=1 selects even parity.
- `stop_bits`  in  1  0 selects one stop bit, 1 selects two.
- `read_data`  out  DATA_WIDTH  last completed word.
- `RX_done`  out  1  one-PCLK pulse when a word completes.
- `RX_ERROR`  out  1  one-PCLK pulse when a word is aborted.
- `parity_error`  out  1  sticky; cleared at the start of the next word.
- `frame_error`  out  1  sticky; cleared at the start of the next word.

## Operation
- `Rx` passes through a 2-flop synchronizer. A falling edge is detected on the synchronized value.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, ERR.
- **IDLE**
  - A falling edge with RX_enable=1 moves to START. The sample counter is cleared.
  - If the bit index is 0, parity_error and frame_error are also cleared.
- **START**
  - Wait OVERSAMPLE/2 ticks, then re-sample.
  - Rx=1 means a false start: return to IDLE. This does not count as an error.
  - Rx=0 moves to DATA. The sample counter restarts.
- **DATA**
  - Sample every OVERSAMPLE ticks, at mid-bit.
  - Bits are LSB first. Each bit is stored at shift_reg[index] while index < DATA_WIDTH.
  - Bits arriving at index >= DATA_WIDTH are dropped from the word but still enter the parity computation.
  - index increments on every data bit, saturating at DATA_WIDTH. bit_cnt counts data bits within the frame.
  - After frame_length bits: go to PARITY if parity_signal[1]=1, otherwise STOP1.
- **PARITY**
  - Sample the parity bit. The check is XOR(frame data bits, parity bit): it must be 1 for odd parity and 0 for even.
  - On mismatch, set parity_error. The frame continues.
- **STOP1**
  - Sample. Rx=0 sets frame_error and moves to ERR.
  - Otherwise go to STOP2 if stop_bits=1.
  - Otherwise go to DONE if index >= DATA_WIDTH, else IDLE.
- **STOP2**
  - Same check as STOP1, then DONE or IDLE.
- **DONE**
  - Load read_data from shift_reg. Pulse RX_done.
  - index returns to 0. Next state is IDLE.
  - A word whose frames had parity mismatches still completes; parity_error stays set alongside RX_done.
- **ERR**
  - Pulse RX_ERROR. Discard the partial word, index returns to 0.
  - Wait until synchronized Rx=1, then go to IDLE. This provides break/line-low tolerance.
- RX_enable=0 in any state: next PCLK goes to IDLE and index returns to 0. read_data and the sticky flags are held.
- Configuration inputs must remain static while not in IDLE with index=0. Changing them mid-word is undefined.

## Timing
- Reset values: read_data=0, RX_done=0, RX_ERROR=0, parity_error=0, frame_error=0, state IDLE, index=0, all counters 0.
- PRESETn assertion mid-frame aborts immediately and asynchronously. No RX_done or RX_ERROR is produced.
- Edge-detect latency: 2 PCLK after Rx falls, plus alignment to the next rx_tick.
- The START check occurs OVERSAMPLE/2 ticks after edge detection. Each later sample is OVERSAMPLE ticks after the previous one.
- RX_done and read_data update on the PCLK edge following the rx_tick that sampled the last stop bit. read_data is held until the next RX_done.
- Sticky flags are valid no later than the cycle RX_done or RX_ERROR pulses.
- Simultaneous RX_enable fall and DONE entry: RX_enable wins, and no RX_done is produced.

## Structure
- Shared package `uart_pkg`:
  - `DATA_WIDTH` and `OVERSAMPLE` constants.
  - rx state enum.
  - parity encodings: PAR_NONE=2'b0x, PAR_ODD=2'b10, PAR_EVEN=2'b11.
  - stop-bit encodings.
  - These are used by both the transmitter and the receiver.
- One sub-module, `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs rx_s and rx_fall. Reset value of rx_s is 1.

## Test plan
- frame_length=8, no parity, 1 stop, 16 ticks/bit, word 0xA5C3_0F12 sent as 4 frames LSB-first -> one RX_done, read_data=0xA5C3_0F12, both sticky flags 0.
- frame_length=5, even parity, 2 stops, word 0xFFFF_FFFF (7 frames, 35 bits, last 3 padded 0) -> read_data=0xFFFF_FFFF, parity_error=0. Flipping the parity bit of frame 3 -> RX_done still pulses with parity_error=1.
- frame_length=7, odd parity, stop bit of frame 2 driven 0 -> RX_ERROR pulse, frame_error=1, no RX_done, read_data keeps its previous value. The next clean word then clears frame_error and completes.
- Rx low glitch of 4 ticks while idle -> stays IDLE, no state change, flags unchanged. The following valid word is received correctly.
- PRESETn pulsed low during frame 2 -> all outputs 0. A fresh 0x1234_5678 then completes correctly.
- RX_enable dropped mid-frame 3 and re-raised -> partial word discarded, no pulses. The next full word 0x0000_00FF is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART transmit and receive paths.
//   - DATA_WIDTH / OVERSAMPLE : default word width and rx_tick pulses per bit
//   - rx_state_t              : receiver state encoding
//   - PAR_* / STOP_*          : parity_signal and stop_bits encodings
//   - parity_ok()             : frame parity check helper
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP1,
    RX_STOP2,
    RX_DONE,
    RX_ERR
  } rx_state_t;

  // parity_signal: bit1 enables parity; bit0 selects even (1) or odd (0).
  // Any value with bit1 clear (2'b0x) means no parity.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_EVEN = 2'b11;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // data_xor is the XOR of the frame's data bits. The XOR of data and
  // parity bit must be 1 for odd parity and 0 for even parity.
  function automatic logic parity_ok(input logic data_xor,
                                     input logic parity_bit,
                                     input logic [1:0] parity_sel);
    return data_xor ^ parity_bit ^ parity_sel[0];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous serial input plus a
//   falling-edge detector on the synchronized value.
//   Ports:
//     PCLK     in   system clock, rising edge
//     PRESETn  in   asynchronous active-low reset
//     Rx       in   raw serial line, idle high
//     rx_s     out  synchronized line (resets to 1, the idle level)
//     rx_fall  out  one-PCLK pulse when rx_s goes 1 -> 0
module uart_rx_sync (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic Rx,
  output logic rx_s,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_prev;

  // All stages reset to the idle level so reset release never looks like
  // a start-bit edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel receive stage. Reassembles one DATA_WIDTH-bit word
//   from consecutive character frames (LSB first), sampling each bit at
//   mid-point using an OVERSAMPLE x baud rx_tick enable. Parity and stop
//   bits are checked per frame; status is reported through one-cycle
//   pulses and sticky flags.
//   Ports:
//     PCLK, PRESETn   system clock / asynchronous active-low reset
//     rx_tick         one-PCLK enable at OVERSAMPLE x baud
//     RX_enable       receive enable; low forces IDLE and drops partial word
//     Rx              asynchronous serial input, idle high
//     frame_length    data bits per frame (5..8)
//     parity_signal   bit1 = parity enable, bit0 = even (1) / odd (0)
//     stop_bits       0 = one stop bit, 1 = two
//     read_data       last completed word, held until the next RX_done
//     RX_done         one-PCLK pulse when a word completes
//     RX_ERROR        one-PCLK pulse when a word is aborted (bad stop bit)
//     parity_error    sticky, cleared when the next word starts
//     frame_error     sticky, cleared when the next word starts
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  rx_tick,
  input  logic                  RX_enable,
  input  logic                  Rx,
  input  logic [3:0]            frame_length,
  input  logic [1:0]            parity_signal,
  input  logic                  stop_bits,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  RX_done,
  output logic                  RX_ERROR,
  output logic                  parity_error,
  output logic                  frame_error
);

  import uart_pkg::*;

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SEL_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(DATA_WIDTH);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .Rx      (Rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_t             state;
  logic [CNT_W-1:0]      sample_cnt;
  logic [IDX_W-1:0]      index;
  logic [3:0]            bit_cnt;
  logic                  par_acc;
  logic [DATA_WIDTH-1:0] shift_reg;

  // Sample strobes: half a bit after the start edge, then every full bit.
  logic      half_hit;
  logic      bit_hit;
  logic      last_data_bit;
  logic      word_full;
  rx_state_t after_stop;

  always_comb begin
    half_hit      = rx_tick && (sample_cnt == HALF_LAST);
    bit_hit       = rx_tick && (sample_cnt == FULL_LAST);
    last_data_bit = ((bit_cnt + 4'd1) == frame_length);
    word_full     = (index >= IDX_FULL);
    after_stop    = word_full ? RX_DONE : RX_IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state        <= RX_IDLE;
      sample_cnt   <= '0;
      index        <= '0;
      bit_cnt      <= '0;
      par_acc      <= 1'b0;
      shift_reg    <= '0;
      read_data    <= '0;
      RX_done      <= 1'b0;
      RX_ERROR     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      RX_done  <= 1'b0;
      RX_ERROR <= 1'b0;

      // Disable has priority over every state, including DONE, so a word
      // finishing in the same cycle as the disable never reports RX_done.
      if (!RX_enable) begin
        state      <= RX_IDLE;
        index      <= '0;
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else begin
        unique case (state)
          RX_IDLE: begin
            if (rx_fall) begin
              state      <= RX_START;
              sample_cnt <= '0;
              bit_cnt    <= '0;
              par_acc    <= 1'b0;
              // First frame of a new word: clear status and stale data.
              if (index == '0) begin
                parity_error <= 1'b0;
                frame_error  <= 1'b0;
                shift_reg    <= '0;
              end
            end
          end

          RX_START: begin
            if (half_hit) begin
              sample_cnt <= '0;
              // Line back high at mid start bit: glitch, not an error.
              state      <= rx_s ? RX_IDLE : RX_DATA;
            end else if (rx_tick) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          RX_DATA: begin
            if (bit_hit) begin
              sample_cnt <= '0;
              // Bits beyond the word width are padding: they still count
              // toward frame parity but are not stored.
              if (!word_full) begin
                shift_reg[index[SEL_W-1:0]] <= rx_s;
                index                       <= index + 1'b1;
              end
              par_acc <= par_acc ^ rx_s;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_data_bit) begin
                state <= parity_signal[1] ? RX_PARITY : RX_STOP1;
              end
            end else if (rx_tick) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          RX_PARITY: begin
            if (bit_hit) begin
              sample_cnt <= '0;
              if (!parity_ok(par_acc, rx_s, parity_signal)) begin
                parity_error <= 1'b1;
              end
              state <= RX_STOP1;
            end else if (rx_tick) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          RX_STOP1: begin
            if (bit_hit) begin
              sample_cnt <= '0;
              if (!rx_s) begin
                frame_error <= 1'b1;
                RX_ERROR    <= 1'b1;
                index       <= '0;
                state       <= RX_ERR;
              end else if (stop_bits == STOP_TWO) begin
                state <= RX_STOP2;
              end else begin
                state <= after_stop;
              end
            end else if (rx_tick) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          RX_STOP2: begin
            if (bit_hit) begin
              sample_cnt <= '0;
              if (!rx_s) begin
                frame_error <= 1'b1;
                RX_ERROR    <= 1'b1;
                index       <= '0;
                state       <= RX_ERR;
              end else begin
                state <= after_stop;
              end
            end else if (rx_tick) begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end

          RX_DONE: begin
            read_data <= shift_reg;
            RX_done   <= 1'b1;
            index     <= '0;
            state     <= RX_IDLE;
          end

          RX_ERR: begin
            // Hold off until the line returns high so a break or stuck-low
            // line cannot be mistaken for a stream of start bits.
            if (rx_s) begin
              state <= RX_IDLE;
            end
          end

          default: begin
            state <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  import uart_pkg::*;

  localparam int unsigned DW       = 32;
  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          rx_tick;
  logic          RX_enable;
  logic          Rx;
  logic [3:0]    frame_length;
  logic [1:0]    parity_signal;
  logic          stop_bits;
  logic [DW-1:0] read_data;
  logic          RX_done;
  logic          RX_ERROR;
  logic          parity_error;
  logic          frame_error;

  always #5 PCLK = ~PCLK;

  uart_receiver #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .rx_tick       (rx_tick),
    .RX_enable     (RX_enable),
    .Rx            (Rx),
    .frame_length  (frame_length),
    .parity_signal (parity_signal),
    .stop_bits     (stop_bits),
    .read_data     (read_data),
    .RX_done       (RX_done),
    .RX_ERROR      (RX_ERROR),
    .parity_error  (parity_error),
    .frame_error   (frame_error)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] word;
    bit          perr;
    bit          ferr;
  } exp_t;

  typedef struct {
    logic [31:0] word;
    int          flen;
    logic [1:0]  par;
    logic        two_stop;
    int          flip_idx;
    int          bad_idx;
    bit          exp_err;
    logic [31:0] exp_word;
    bit          exp_perr;
    bit          exp_ferr;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   errors   = 0;
  int   tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One PCLK: sample at the falling edge, compare any pulse against the
  // scoreboard, then advance the rx_tick divider.
  task automatic step();
    @(negedge PCLK);
    if (RX_done === 1'b1 || RX_ERROR === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: RX_done=%b RX_ERROR=%b expected no pulse",
                 RX_done, RX_ERROR);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("RX_done", 32'(RX_done), 32'(!e.is_err));
        check("RX_ERROR", 32'(RX_ERROR), 32'(e.is_err));
        check("read_data", read_data, e.word);
        check("parity_error", 32'(parity_error), 32'(e.perr));
        check("frame_error", 32'(frame_error), 32'(e.ferr));
      end
    end
    rx_tick  = (tick_cnt == int'(TICK_DIV) - 1);
    tick_cnt = (tick_cnt + 1) % int'(TICK_DIV);
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (BIT_CLKS) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input int flen, input logic [1:0] par,
                            input logic two_stop, input bit flip, input bit bad_stop);
    logic p;
    logic pb;
    p = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < flen; i++) begin
      drive_bit(d[i]);
      p = p ^ d[i];
    end
    if (par[1]) begin
      pb = (par == PAR_EVEN) ? p : ~p;
      drive_bit(pb ^ flip);
    end
    drive_bit(!bad_stop);
    if (two_stop) drive_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w, input int flen, input logic [1:0] par,
                           input logic two_stop, input int flip_idx, input int bad_idx);
    int         nfr;
    logic [7:0] d;
    frame_length  = 4'(flen);
    parity_signal = par;
    stop_bits     = two_stop;
    nfr = (int'(DW) + flen - 1) / flen;
    for (int f = 0; f < nfr; f++) begin
      d = '0;
      for (int i = 0; i < flen; i++) begin
        if (f * flen + i < int'(DW)) d[i] = w[f * flen + i];
      end
      send_frame(d, flen, par, two_stop, f == flip_idx, f == bad_idx);
      if (f == bad_idx) break;
    end
    Rx = 1'b1;
    repeat (2 * BIT_CLKS) step();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && sbq.size() != 0; i++) step();
    check(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    vecs[0] = '{32'hA5C3_0F12, 8, PAR_NONE, STOP_ONE, -1, -1, 1'b0, 32'hA5C3_0F12, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 5, PAR_EVEN, STOP_TWO, -1, -1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 5, PAR_EVEN, STOP_TWO,  2, -1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h1357_9BDF, 7, PAR_ODD,  STOP_ONE, -1,  1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h2468_ACE0, 7, PAR_ODD,  STOP_ONE, -1, -1, 1'b0, 32'h2468_ACE0, 1'b0, 1'b0};
    vecs[5] = '{32'h0F0F_55AA, 6, PAR_ODD,  STOP_TWO, -1, -1, 1'b0, 32'h0F0F_55AA, 1'b0, 1'b0};

    PRESETn       = 1'b0;
    rx_tick       = 1'b0;
    RX_enable     = 1'b1;
    Rx            = 1'b1;
    frame_length  = 4'd8;
    parity_signal = PAR_NONE;
    stop_bits     = STOP_ONE;
    repeat (5) step();
    #1;
    check("reset_read_data", read_data, 32'h0);
    check("reset_RX_done", 32'(RX_done), 32'd0);
    check("reset_RX_ERROR", 32'(RX_ERROR), 32'd0);
    check("reset_parity_error", 32'(parity_error), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    PRESETn = 1'b1;
    repeat (BIT_CLKS) step();

    for (int unsigned k = 0; k < 6; k++) begin
      sbq.push_back('{vecs[k].exp_err, vecs[k].exp_word, vecs[k].exp_perr, vecs[k].exp_ferr});
      send_word(vecs[k].word, vecs[k].flen, vecs[k].par, vecs[k].two_stop,
                vecs[k].flip_idx, vecs[k].bad_idx);
      drain($sformatf("drain_vec%0d", k));
    end

    // Short low glitch while idle: rejected at the mid-start check.
    Rx = 1'b0;
    repeat (4 * TICK_DIV) step();
    Rx = 1'b1;
    repeat (3 * BIT_CLKS) step();
    check("glitch_read_data", read_data, 32'h0F0F_55AA);
    check("glitch_parity_error", 32'(parity_error), 32'd0);
    check("glitch_frame_error", 32'(frame_error), 32'd0);
    sbq.push_back('{1'b0, 32'h5A5A_C3C3, 1'b0, 1'b0});
    send_word(32'h5A5A_C3C3, 8, PAR_EVEN, STOP_ONE, -1, -1);
    drain("drain_glitch");

    // Asynchronous reset in the middle of frame 2.
    frame_length  = 4'd8;
    parity_signal = PAR_NONE;
    stop_bits     = STOP_ONE;
    send_frame(8'h0D, 8, PAR_NONE, STOP_ONE, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    PRESETn = 1'b0;
    #1;
    check("areset_read_data", read_data, 32'h0);
    check("areset_RX_done", 32'(RX_done), 32'd0);
    check("areset_RX_ERROR", 32'(RX_ERROR), 32'd0);
    check("areset_parity_error", 32'(parity_error), 32'd0);
    check("areset_frame_error", 32'(frame_error), 32'd0);
    Rx = 1'b1;
    repeat (10) step();
    PRESETn = 1'b1;
    repeat (BIT_CLKS) step();
    sbq.push_back('{1'b0, 32'h1234_5678, 1'b0, 1'b0});
    send_word(32'h1234_5678, 8, PAR_NONE, STOP_ONE, -1, -1);
    drain("drain_after_reset");

    // Receive disabled in the middle of frame 3.
    send_frame(8'hEF, 8, PAR_NONE, STOP_ONE, 1'b0, 1'b0);
    send_frame(8'hBE, 8, PAR_NONE, STOP_ONE, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RX_enable = 1'b0;
    repeat (8) step();
    check("disable_read_data_held", read_data, 32'h1234_5678);
    Rx = 1'b1;
    repeat (BIT_CLKS) step();
    RX_enable = 1'b1;
    repeat (BIT_CLKS) step();
    sbq.push_back('{1'b0, 32'h0000_00FF, 1'b0, 1'b0});
    send_word(32'h0000_00FF, 8, PAR_NONE, STOP_ONE, -1, -1);
    drain("drain_after_disable");
    check("final_read_data", read_data, 32'h0000_00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
